// File: rtl/duv_mon_pkg.sv
// Shared types and defaults for the DUV output monitor.
package duv_mon_pkg;

    localparam int MON_TS_W  = 16;
    localparam int MON_DEPTH = 8;

    // Layout of one logged event at the default timestamp width.
    // The top packs its FIFO word in the same order: {ts, a, b}.
    typedef struct packed {
        logic [MON_TS_W-1:0] ts;
        logic [1:0]          a;
        logic [1:0]          b;
    } mon_evt_t;

    // True when the sampled output pair differs from the previous sample.
    function automatic logic ab_changed(input logic [3:0] cur_ab, input logic [3:0] prev_ab);
        return (cur_ab != prev_ab);
    endfunction

endpackage

// File: rtl/duv_out_monitor_if.sv
// Event drain port: valid/ready handshake carrying the head of the change log.
interface duv_out_monitor_if
    import duv_mon_pkg::*;
#(
    parameter int TS_W = MON_TS_W
);
    logic            evt_valid;
    logic            evt_ready;
    logic [TS_W-1:0] evt_ts;
    logic [1:0]      evt_a;
    logic [1:0]      evt_b;

    modport master (
        output evt_valid,
        output evt_ts,
        output evt_a,
        output evt_b,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_ts,
        input  evt_a,
        input  evt_b,
        output evt_ready
    );
endinterface

// File: rtl/mon_sync_fifo.sv
// Generic first-word-fall-through FIFO with explicit occupancy counter.
// A pop while empty is ignored; a push while full is accepted only when a
// pop happens in the same cycle.
module mon_sync_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic             do_pop_s;
    logic             do_push_s;

    assign full  = (level_r == LVL_FULL);
    assign empty = (level_r == {LVL_W{1'b0}});
    assign level = level_r;
    assign dout  = mem_r[rd_ptr_r];

    // Qualify requests: pop needs data, push needs room or a concurrent pop.
    always_comb begin
        do_pop_s  = 1'b0;
        do_push_s = 1'b0;
        if (pop && !empty) begin
            do_pop_s = 1'b1;
        end else begin
            do_pop_s = 1'b0;
        end
        if (push && (!full || do_pop_s)) begin
            do_push_s = 1'b1;
        end else begin
            do_push_s = 1'b0;
        end
    end

    // Storage: cleared on reset so the head reads zero while empty.
    always_ff @(posedge clk) begin
        if (arst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); level tracks occupancy.
    always_ff @(posedge clk) begin
        if (arst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/duv_out_monitor.sv
// Change logger for the DUV's two 2-bit outputs: samples the pair every
// clock, pushes {timestamp, a, b} into a FWFT FIFO on every change, and
// flags (sticky) any event dropped because the FIFO was full.
module duv_out_monitor
    import duv_mon_pkg::*;
#(
    parameter int DEPTH = MON_DEPTH,
    parameter int TS_W  = MON_TS_W
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic                   en,
    input  logic [1:0]             out_a,
    input  logic [1:0]             out_b,
    input  logic                   clr_ovf,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    duv_out_monitor_if.master      evt
);
    localparam int EVT_W = TS_W + 4;
    localparam logic [TS_W-1:0] TS_ONE = TS_W'(1);

    logic [TS_W-1:0]  ts_cnt_r;
    logic [TS_W-1:0]  s_ts_r;
    logic [3:0]       s_ab_r;
    logic [3:0]       p_ab_r;
    logic             overflow_r;
    logic             push_s;
    logic             pop_s;
    logic             drop_s;
    logic             full_s;
    logic             empty_s;
    logic [EVT_W-1:0] head_s;

    // Free-running timestamp (gated by en) plus the sample and compare stages.
    // p_ab follows s_ab regardless of en so re-enabling never sees a stale diff.
    always_ff @(posedge clk) begin
        if (arst) begin
            ts_cnt_r <= {TS_W{1'b0}};
            s_ts_r   <= {TS_W{1'b0}};
            s_ab_r   <= 4'b0000;
            p_ab_r   <= 4'b0000;
        end else begin
            if (en) begin
                ts_cnt_r <= ts_cnt_r + TS_ONE;
            end else begin
                ts_cnt_r <= ts_cnt_r;
            end
            s_ab_r <= {out_a, out_b};
            s_ts_r <= ts_cnt_r;
            p_ab_r <= s_ab_r;
        end
    end

    // Push/pop decisions; a drop is a push that the full FIFO cannot take.
    always_comb begin
        push_s = 1'b0;
        pop_s  = 1'b0;
        drop_s = 1'b0;
        if (en && ab_changed(s_ab_r, p_ab_r)) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        if (!empty_s && evt.evt_ready) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        if (push_s && full_s && !pop_s) begin
            drop_s = 1'b1;
        end else begin
            drop_s = 1'b0;
        end
    end

    // Sticky overflow flag; a drop in the same cycle as clr_ovf keeps it set.
    always_ff @(posedge clk) begin
        if (arst) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (clr_ovf) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    mon_sync_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .arst  (arst),
        .push  (push_s),
        .pop   (pop_s),
        .din   ({s_ts_r, s_ab_r}),
        .dout  (head_s),
        .full  (full_s),
        .empty (empty_s),
        .level (level)
    );

    assign overflow      = overflow_r;
    assign evt.evt_valid = !empty_s;
    assign evt.evt_ts    = head_s[EVT_W-1:4];
    assign evt.evt_a     = head_s[3:2];
    assign evt.evt_b     = head_s[1:0];

endmodule

// File: tb/tb_duv_out_monitor.sv
// Directed bench for duv_out_monitor. Two instances share all inputs:
// dut (DEPTH=4, TS_W=16) for the main log checks and dutw (DEPTH=8, TS_W=4)
// for timestamp wrap; dutw timestamps are the dut timestamps modulo 16.
module tb_duv_out_monitor;

    logic       clk = 1'b0;
    logic       arst;
    logic       en;
    logic [1:0] out_a;
    logic [1:0] out_b;
    logic       clr_ovf;
    logic       ready;
    logic [2:0] level;
    logic       overflow;
    logic [3:0] wlevel;
    logic       woverflow;

    int vec_cnt    = 0;
    int miscmp_cnt = 0;
    int ts_m       = 0;
    int ts_cap     = 0;
    int guard      = 0;

    duv_out_monitor_if #(.TS_W(16)) evt_if ();
    duv_out_monitor_if #(.TS_W(4))  wevt_if ();

    assign evt_if.evt_ready  = ready;
    assign wevt_if.evt_ready = ready;

    duv_out_monitor #(.DEPTH(4), .TS_W(16)) dut (
        .clk      (clk),
        .arst     (arst),
        .en       (en),
        .out_a    (out_a),
        .out_b    (out_b),
        .clr_ovf  (clr_ovf),
        .level    (level),
        .overflow (overflow),
        .evt      (evt_if)
    );

    duv_out_monitor #(.DEPTH(8), .TS_W(4)) dutw (
        .clk      (clk),
        .arst     (arst),
        .en       (en),
        .out_a    (out_a),
        .out_b    (out_b),
        .clr_ovf  (clr_ovf),
        .level    (wlevel),
        .overflow (woverflow),
        .evt      (wevt_if)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n clocks; the model counter mirrors the documented ts_cnt rules.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (arst) ts_m = 0;
            else if (en) ts_m = ts_m + 1;
            #1;
        end
    endtask

    task automatic set_ab(input logic [3:0] v);
        {out_a, out_b} = v;
    endtask

    task automatic do_reset();
        set_ab(4'b0000);
        arst = 1'b1;
        step(1);
        arst = 1'b0;
    endtask

    task automatic check_head(input string tag, input int ts, input logic [3:0] ab);
        check_vec({tag, "_valid"}, {31'd0, evt_if.evt_valid}, 32'd1);
        check_vec({tag, "_ts"}, {16'd0, evt_if.evt_ts}, ts & 32'hFFFF);
        check_vec({tag, "_ab"}, {28'd0, evt_if.evt_a, evt_if.evt_b}, {28'd0, ab});
    endtask

    initial begin
        arst = 1'b1; en = 1'b0; clr_ovf = 1'b0; ready = 1'b0;
        set_ab(4'b0000);
        step(2);
        arst = 1'b0;
        en   = 1'b1;

        // Reset state
        check_vec("rst_valid", {31'd0, evt_if.evt_valid}, 32'd0);
        check_vec("rst_level", {29'd0, level}, 32'd0);
        check_vec("rst_ovf", {31'd0, overflow}, 32'd0);
        check_vec("rst_ts", {16'd0, evt_if.evt_ts}, 32'd0);
        check_vec("rst_ab", {28'd0, evt_if.evt_a, evt_if.evt_b}, 32'd0);

        // Idle 20 clocks, then a change proves the counter reached 20
        step(20);
        check_vec("idle_valid", {31'd0, evt_if.evt_valid}, 32'd0);
        check_vec("idle_level", {29'd0, level}, 32'd0);
        set_ab(4'b0010);
        step(1);
        check_vec("lat1_valid", {31'd0, evt_if.evt_valid}, 32'd0);
        step(1);
        check_head("idle20", 20, 4'b0010);
        check_vec("idle20_wts", {28'd0, wevt_if.evt_ts}, 32'd4);
        ready = 1'b1;
        step(1);
        ready = 1'b0;
        check_vec("idle20_drain", {29'd0, level}, 32'd0);

        // Single change at ts 5
        do_reset();
        step(5);
        set_ab(4'b0100);
        step(1);
        check_vec("single_lat1", {31'd0, evt_if.evt_valid}, 32'd0);
        step(1);
        check_head("single", 5, 4'b0100);
        ready = 1'b1;
        step(1);
        ready = 1'b0;
        check_vec("single_level", {29'd0, level}, 32'd0);
        check_vec("single_novalid", {31'd0, evt_if.evt_valid}, 32'd0);

        // Burst of six changes into a 4-deep log
        do_reset();
        for (int k = 0; k < 6; k++) begin
            set_ab(4'(k + 1));
            step(1);
        end
        step(2);
        check_vec("burst_level", {29'd0, level}, 32'd4);
        check_vec("burst_ovf", {31'd0, overflow}, 32'd1);
        check_vec("burst_wlevel", {28'd0, wlevel}, 32'd6);
        check_vec("burst_wovf", {31'd0, woverflow}, 32'd0);
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_head("burst_head", i, 4'(i + 1));
            step(1);
        end
        check_vec("burst_empty", {29'd0, level}, 32'd0);
        check_vec("burst_whead", {28'd0, wevt_if.evt_ts}, 32'd4);
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        check_vec("clr_ovf", {31'd0, overflow}, 32'd0);
        step(1);
        ready = 1'b0;
        check_vec("burst_wempty", {28'd0, wlevel}, 32'd0);

        // Full FIFO with push and pop on the same edge
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_ab(4'(k + 1));
            step(1);
        end
        step(1);
        check_vec("full_level", {29'd0, level}, 32'd4);
        set_ab(4'b0101);
        step(1);
        ready = 1'b1;
        step(1);
        ready = 1'b0;
        check_vec("pp_level", {29'd0, level}, 32'd4);
        check_vec("pp_ovf", {31'd0, overflow}, 32'd0);
        ready = 1'b1;
        check_head("pp_h0", 1, 4'b0010);
        step(1);
        check_head("pp_h1", 2, 4'b0011);
        step(1);
        check_head("pp_h2", 3, 4'b0100);
        step(1);
        check_head("pp_tail", 5, 4'b0101);
        step(1);
        ready = 1'b0;
        check_vec("pp_empty", {29'd0, level}, 32'd0);

        // Enable gating: toggles while disabled are ignored, counter frozen
        en = 1'b0;
        set_ab(4'b1010); step(1);
        set_ab(4'b0101); step(1);
        set_ab(4'b1111); step(1);
        set_ab(4'b0000); step(3);
        check_vec("gate_level", {29'd0, level}, 32'd0);
        en = 1'b1;
        step(3);
        check_vec("stale_level", {29'd0, level}, 32'd0);
        check_vec("stale_wlevel", {28'd0, wlevel}, 32'd0);
        ts_cap = ts_m;
        set_ab(4'b0011);
        step(2);
        check_head("frozen_ts", ts_cap, 4'b0011);
        ready = 1'b1;
        step(1);
        ready = 1'b0;

        // Timestamp wrap on the 4-bit instance
        guard = 0;
        while (((ts_m % 16) != 15) && (guard < 40)) begin
            step(1);
            guard++;
        end
        check_vec("wrap_reach", ts_m % 16, 32'd15);
        ts_cap = ts_m;
        set_ab(4'b1100);
        step(1);
        set_ab(4'b1101);
        step(2);
        check_vec("wrap_wlevel", {28'd0, wlevel}, 32'd2);
        check_vec("wrap_w15", {28'd0, wevt_if.evt_ts}, 32'd15);
        check_head("wrap_full_ts", ts_cap, 4'b1100);
        ready = 1'b1;
        step(1);
        check_vec("wrap_w0", {28'd0, wevt_if.evt_ts}, 32'd0);
        check_vec("wrap_wab", {28'd0, wevt_if.evt_a, wevt_if.evt_b}, 32'd13);
        step(1);
        ready = 1'b0;

        // Reset mid-operation with pending events and overflow set
        for (int k = 0; k < 5; k++) begin
            set_ab(4'(k + 6));
            step(1);
        end
        step(2);
        check_vec("pre_rst_level", {29'd0, level}, 32'd4);
        check_vec("pre_rst_ovf", {31'd0, overflow}, 32'd1);
        set_ab(4'b1110);
        arst = 1'b1;
        step(1);
        arst = 1'b0;
        set_ab(4'b0000);
        check_vec("mid_rst_level", {29'd0, level}, 32'd0);
        check_vec("mid_rst_valid", {31'd0, evt_if.evt_valid}, 32'd0);
        check_vec("mid_rst_ovf", {31'd0, overflow}, 32'd0);
        check_vec("mid_rst_ts", {16'd0, evt_if.evt_ts}, 32'd0);
        check_vec("mid_rst_wlevel", {28'd0, wlevel}, 32'd0);
        step(2);
        check_vec("post_rst_none", {29'd0, level}, 32'd0);
        set_ab(4'b1000);
        step(2);
        check_head("post_rst", 2, 4'b1000);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
